line_clear_seq: RTL

Sequencer that performs Tetris line clearing on a row-organised board memory. The game controller pulses a start request after a piece is placed. The block then scans the board bottom-to-top through a single-port row interface, drops every non-full row down over the cleared ones, and zero-fills the rows vacated at the top. It sits between the game state machine (start/done handshake) and the board row RAM, which it owns exclusively while busy.

---
 rtl/line_clear_seq_pkg.sv | 22 ++
 rtl/line_clear_seq_row_full_chk.sv | 16 +
 rtl/line_clear_seq.sv | 110 +++++++++++
 3 files changed

// File: rtl/line_clear_seq_pkg.sv
// Shared board constants, pass FSM encoding and a row-full helper for the
// line-clear sequencer, draw and game blocks.
package line_clear_seq_pkg;
  localparam int ROWS = 20;
  localparam int COLS = 10;
  localparam int CW   = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_EVAL,
    S_FILL,
    S_DONE
  } state_e;

  function automatic logic row_full(input logic [COLS*CW-1:0] row);
    logic f;
    f = 1'b1;
    for (int c = 0; c < COLS; c++) f &= |row[c*CW +: CW];
    return f;
  endfunction
endpackage

// File: rtl/line_clear_seq_row_full_chk.sv
// Combinational full-row detect: every cell nibble must be nonzero.
module row_full_chk #(
  parameter int COLS = 10,
  parameter int CW   = 4
) (
  input  logic [COLS*CW-1:0] row_i,
  output logic               full_o
);
  logic [COLS-1:0] occ;

  for (genvar c = 0; c < COLS; c++) begin : g_cell
    assign occ[c] = |row_i[c*CW +: CW];
  end

  assign full_o = &occ;
endmodule

// File: rtl/line_clear_seq.sv
// Line-clear pass: scans the board bottom-up, compacts non-full rows downward
// and zero-fills the vacated top rows, then reports the cleared-line count.
import line_clear_seq_pkg::*;

module line_clear_seq #(
  parameter int ROWS = line_clear_seq_pkg::ROWS,
  parameter int COLS = line_clear_seq_pkg::COLS,
  parameter int CW   = line_clear_seq_pkg::CW
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_start,
  output logic               o_busy,
  output logic               o_done,
  output logic [4:0]         o_row_addr,
  output logic               o_row_re,
  input  logic [COLS*CW-1:0] i_row_rdata,
  output logic               o_row_we,
  output logic [COLS*CW-1:0] o_row_wdata,
  output logic [4:0]         o_lines,
  input  logic               i_clear_total,
  output logic [9:0]         o_total
);
  state_e            state_q;
  logic signed [5:0] src_q, dst_q, dst_d;
  logic [4:0]        cnt_q, lines_q;
  logic [9:0]        total_q, total_d;
  logic [10:0]       sum;
  logic              full;

  row_full_chk #(.COLS(COLS), .CW(CW)) u_full (
    .row_i  (i_row_rdata),
    .full_o (full)
  );

  // dst only moves past a row that survives; -1 marks nothing left to fill
  assign dst_d   = full ? dst_q : dst_q - 6'sd1;
  assign sum     = {1'b0, total_q} + {6'b0, cnt_q};
  assign total_d = sum[10] ? 10'h3FF : sum[9:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      lines_q <= '0;
      total_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (i_start) begin
          src_q   <= 6'(ROWS - 1);
          dst_q   <= 6'(ROWS - 1);
          cnt_q   <= '0;
          state_q <= S_READ;
        end
        S_READ: state_q <= S_EVAL;
        S_EVAL: begin
          src_q <= src_q - 6'sd1;
          dst_q <= dst_d;
          if (full) cnt_q <= cnt_q + 5'd1;
          if (src_q > 6'sd0)       state_q <= S_READ;
          else if (dst_d >= 6'sd0) state_q <= S_FILL;
          else                     state_q <= S_DONE;
        end
        S_FILL: begin
          dst_q <= dst_q - 6'sd1;
          if (dst_q == 6'sd0) state_q <= S_DONE;
        end
        S_DONE: begin
          lines_q <= cnt_q;
          total_q <= total_d;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
      // a clear in the DONE cycle overrides the accumulate above
      if (i_clear_total) total_q <= '0;
    end
  end

  // RAM port is decoded from state: EVAL write data is the same-cycle read data
  always_comb begin
    o_row_re    = 1'b0;
    o_row_we    = 1'b0;
    o_row_addr  = '0;
    o_row_wdata = '0;
    case (state_q)
      S_READ: begin
        o_row_re   = 1'b1;
        o_row_addr = src_q[4:0];
      end
      S_EVAL: if (!full && (src_q != dst_q)) begin
        o_row_we    = 1'b1;
        o_row_addr  = dst_q[4:0];
        o_row_wdata = i_row_rdata;
      end
      S_FILL: begin
        o_row_we   = 1'b1;
        o_row_addr = dst_q[4:0];
      end
      default: ;
    endcase
  end

  assign o_busy  = (state_q != S_IDLE) && (state_q != S_DONE);
  assign o_done  = (state_q == S_DONE);
  assign o_lines = lines_q;
  assign o_total = total_q;
endmodule
